// File: rtl/serial_add_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_sub_ctrl
//
// Bit-serial WIDTH-bit adder/subtractor sequencer. A single 1-bit full
// adder/subtractor cell is driven one operand bit per clock, LSB first, with
// the carry/borrow recirculated through a flip-flop. Word-level requests use a
// start/busy/done handshake.
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN
//   When defined, the overflow output exists and signed overflow is computed
//   from the operand signs latched at start and the final result MSB.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 2)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request pulse, accepted in IDLE or DONE
//   mode      0 = add (a+b+cin), 1 = subtract (a-b-cin, cin is borrow-in)
//   a, b      operands, sampled with an accepted start
//   cin       carry-in / borrow-in, sampled with an accepted start
//   busy      high while bits are being processed
//   done      one-cycle pulse; result/cout (and overflow) are final
//   result    sum/difference, held until the next accepted start clears it
//   cout      final carry-out / borrow-out, held with result
//   overflow  signed overflow (SERIAL_ADDSUB_OVF_EN only)
// ---------------------------------------------------------------------------
module serial_add_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic             mode_r;
  logic             cy;
  logic [CW-1:0]    cnt;

  // 1-bit arithmetic cell
  logic cell_in1;
  logic cell_in2;
  logic cell_p;
  logic sum_diff;
  logic carry_borr;

  logic accept;
  logic last_bit;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    cell_in1 = sha[0];
    cell_in2 = shb[0];
    cell_p   = cell_in1 ^ cell_in2;
    sum_diff = cell_p ^ cy;
    if (mode_r) begin
      carry_borr = (~cell_in1 & cell_in2) | (~cell_p & cy);
    end else begin
      carry_borr = (cell_in1 & cell_in2) | (cy & cell_p);
    end
  end

  // A new operation may start from IDLE or straight out of DONE, which
  // allows back-to-back operations every WIDTH+1 cycles.
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the shift registers are plain flops (not a memory array), so they
  // are cleared by the asynchronous reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sha    <= '0;
      shb    <= '0;
      mode_r <= 1'b0;
      cy     <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            sha    <= a;
            shb    <= b;
            mode_r <= mode;
            cy     <= cin;
            cnt    <= '0;
            result <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          // Operands shift out LSB first; result fills from the MSB side so
          // that after WIDTH shifts bit 0 lands in result[0].
          sha    <= sha >> 1;
          shb    <= shb >> 1;
          result <= {sum_diff, result[WIDTH-1:1]};
          cy     <= carry_borr;
          if (last_bit) begin
            cnt   <= '0;
            cout  <= carry_borr;
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic sign_a;
  logic sign_b;

  // The operands are consumed by shifting, so their signs are kept aside.
  // On the final bit sum_diff is the result MSB being written this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      sign_a <= a[M];
      sign_b <= b[M];
    end else if ((state == RUN) && last_bit) begin
      if (mode_r) begin
        overflow <= (sign_a != sign_b) && (sum_diff != sign_a);
      end else begin
        overflow <= (sign_a == sign_b) && (sum_diff != sign_a);
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sub_ctrl
//
// Self-checking bench for serial_add_sub_ctrl (WIDTH=8). A word-level model
// (plain integer arithmetic plus a countdown of remaining bit cycles) predicts
// busy/done/result/cout every cycle; directed operations also check
// hand-computed literal results. Define SERIAL_ADDSUB_OVF_EN to also check
// overflow.
// ---------------------------------------------------------------------------
module tb_serial_add_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         overflow;
`endif

  int n_vec;
  int n_err;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- word-level reference model ----------------
  function automatic logic [W-1:0] f_res(input logic m, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic c);
    int r;
    r = m ? (int'(x) - int'(y) - int'(c)) : (int'(x) + int'(y) + int'(c));
    return W'(r);
  endfunction

  function automatic logic f_cout(input logic m, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic c);
    int r;
    if (m) return (int'(x) - int'(y) - int'(c)) < 0;
    r = int'(x) + int'(y) + int'(c);
    return r >= (1 << W);
  endfunction

  function automatic logic f_ovf(input logic m, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [W-1:0] r);
    if (m) return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  int           m_left;     // bit cycles still to run
  logic         m_done;
  logic [W-1:0] m_res;
  logic         m_cout;
  logic         m_ovf;
  logic [W-1:0] p_res;      // pending values for the operation in flight
  logic         p_cout;
  logic         p_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= p_res;
        m_cout <= p_cout;
        m_ovf  <= p_ovf;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left <= W;
        m_res  <= '0;
        p_res  <= f_res(mode, a, b, cin);
        p_cout <= f_cout(mode, a, b, cin);
        p_ovf  <= f_ovf(mode, a, b, f_res(mode, a, b, cin));
      end
    end
  end

  // Cycle-by-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      check("busy_done_excl", busy & done, 1'b0);
      if (m_left == 0) begin
        check("result", result, m_res);
        check("cout", cout, m_cout);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("overflow", overflow, m_ovf);
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(input string tag, output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = i;
        break;
      end
    end
    if (edges == 0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string tag, input logic m, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic ic, input logic [W-1:0] er,
                        input logic ec, input logic eo);
    int edges;
    @(negedge clk);
    mode = m; a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_cleared"}, result, '0);
    check({tag, "_busy0"}, busy, 1'b1);
    wait_done(tag, edges);
    // done appears W edges after the start edge: the (W+1)th cycle counted
    // inclusively from the start cycle.
    check({tag, "_latency"}, edges, W);
    check({tag, "_res"}, result, er);
    check({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
    check({tag, "_ovf"}, overflow, eo);
`else
    if (eo === 1'bx) check({tag, "_ovf_x"}, 0, 1);
`endif
  endtask

  initial begin
    int edges;
    int busy_cnt;
    int d1;
    int d2;
    int dones;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, '0);
    check("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("rst_ovf", overflow, 1'b0);
`endif
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op("add5a3c", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("addff01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub1020", 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    run_op("sub8001", 1'b1, 8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b1);
    run_op("add7f00c", 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    run_op("sub0000b", 1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start re-pulsed in RUN with different operands: ignored
    @(negedge clk);
    mode = 1'b0; a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1; mode = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      else break;
    end
    check("repulse_busy_len", busy_cnt, W);
    check("repulse_done", done, 1'b1);
    check("repulse_res", result, 8'h96);
    check("repulse_cout", cout, 1'b0);

    // start held through DONE: back-to-back, operands changed for the second
    @(negedge clk);
    mode = 1'b0; a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    d1 = 0; d2 = 0; dones = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (dones == 1) begin
          d1 = i;
          check("b2b_res1", result, 8'h00);
          check("b2b_cout1", cout, 1'b1);
          mode = 1'b1; a = 8'h10; b = 8'h20;
        end else begin
          d2 = i;
          start = 1'b0;
          check("b2b_res2", result, 8'hF0);
          check("b2b_cout2", cout, 1'b1);
          break;
        end
      end
    end
    check("b2b_first", d1, W);
    check("b2b_period", d2 - d1, W + 1);

    // asynchronous reset mid-operation
    repeat (2) @(negedge clk);
    mode = 1'b0; a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_result", result, '0);
    check("arst_cout", cout, 1'b0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("arst_ovf", overflow, 1'b0);
`endif
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("arst_no_done", dones, 0);
    run_op("post_rst", 1'b1, 8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_add_sub_ctrl.md
# serial_add_sub_ctrl

Bit-serial N-bit adder/subtractor sequencer built around a single 1-bit full adder/subtractor cell. It latches two WIDTH-bit operands, a mode and a carry/borrow-in. It then drives the cell one bit per clock, LSB first, recirculating the carry/borrow through a flip-flop. The block sits between a register-level requester and the 1-bit arithmetic cell, and makes one cell serve word-wide operations through a start/busy/done handshake.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled in IDLE or DONE
- mode  input  1  0 = add (a+b+cin), 1 = subtract (a−b−cin, cin is borrow-in)
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- cin  input  1  carry-in (add) / borrow-in (sub), sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  sum/difference, held until next accepted start
- cout  output  1  final carry-out (add) / borrow-out (sub)
- overflow  output  1  signed overflow (only with SERIAL_ADDSUB_OVF_EN)

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1:
  - Load a→sha, b→shb, mode→mode_r, cin→cy, bit counter→0, result→0.
  - Go to RUN.
- RUN, each cycle:
  - Cell inputs: in1=sha[0], in2=shb[0], mode=mode_r, carryin=cy.
  - sha and shb shift right by 1.
  - sum_diff shifts into result[WIDTH-1], and result shifts right.
  - cy ← carry_borr.
  - The counter increments.
  - When the counter reaches WIDTH-1, the last bit is processed and the state goes to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Go to IDLE unless start=1, which starts a new operation (back-to-back accepted).
- Cell function:
  - add: s=a^b^c, co=ab|c(a^b).
  - sub: d=a^b^c, bo=(~a&b)|(~(a^b)&c).
- cout = cy after the final bit. It is held with result.
- start while in RUN is ignored. No queueing.
- mode, a, b and cin changing while in RUN have no effect.
- Reset: state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0, internal shift registers and counter=0.
- Reset mid-operation aborts immediately; no done is produced.

## Timing
- start sampled high at edge E0 → busy=1 from after E0.
- Bit k is processed at edge E(k+1), k=0..WIDTH-1.
- At edge E(WIDTH): state=DONE, busy=0, done=1, result/cout final.
- Latency from start edge to done: WIDTH+1 cycles from the start edge to the done cycle.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts.
- busy and done are never high in the same cycle.
- result and cout hold their values through DONE and IDLE until the next accepted start, which clears result.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - The overflow port exists.
  - The MSB signs of a and b are registered at start.
  - At edge E(WIDTH):
    - add: overflow = (a[M]==b[M]) && (result[M]!=a[M]).
    - sub: overflow = (a[M]!=b[M]) && (result[M]!=a[M]).
    - M = WIDTH-1.
  - overflow is held with result.
- SERIAL_ADDSUB_OVF_EN undefined: no overflow port and no sign registers. All other behaviour is identical.

## Test plan
- WIDTH=8:
  - add, a=0x5A, b=0x3C, cin=0 → done 9 cycles after start edge, result=0x96, cout=0, overflow=1.
  - add, a=0xFF, b=0x01, cin=0 → result=0x00, cout=1, overflow=0.
  - sub, a=0x10, b=0x20, cin=0 → result=0xF0, cout(borrow)=1, overflow=0.
  - sub, a=0x80, b=0x01, cin=1 → result=0x7E, cout=0, overflow=1.
- Protocol:
  - start re-pulsed at cycle 3 of RUN with different operands → ignored; first result unchanged; busy stays 1 for 8 cycles.
  - start held high in the DONE cycle → new operation begins; done pulses every 9 cycles.
- Reset:
  - rst asserted asynchronously at RUN cycle 4 → all outputs 0 immediately, state IDLE, no done.
  - The next start completes correctly.
